wb_cpu_arbiter: RTL

WB_CPU_ARBITER -- requirements
Module: wb_cpu_arbiter

---
 rtl/wb_cpu_arbiter_pkg.sv | 30 +++
 rtl/wb_arb_timer.sv | 31 +++
 rtl/wb_cpu_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/wb_cpu_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone CPU arbiter: state encoding,
// owner codes, cycle-type constants and default timeout sizing.
package wb_cpu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_I    = 2'b01;
    localparam logic [1:0] OWNER_D    = 2'b10;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int DEFAULT_TIMEOUT    = 1024;
    localparam int DEFAULT_TIMER_BITS = 11;

    function automatic logic [1:0] owner_code(arb_state_t s);
        case (s)
            GNT_I:   return OWNER_I;
            GNT_D:   return OWNER_D;
            default: return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// Counts stb-without-ack cycles of the current grant; expired fires
// combinationally on the TIMEOUT-th such cycle.
module wb_arb_timer
    import wb_cpu_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int TIMER_BITS = DEFAULT_TIMER_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TIMER_BITS-1:0] LAST_COUNT = TIMER_BITS'(TIMEOUT - 1);

    logic [TIMER_BITS-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    // count_q holds the cycles already waited, so this is the TIMEOUT-th one
    assign expired = inc && (count_q == LAST_COUNT);

endmodule

// File: rtl/wb_cpu_arbiter.sv
// Arbitrates the instruction and data Wishbone masters onto one shared bus,
// with round-robin tie breaking and a watchdog on unacknowledged strobes.
module wb_cpu_arbiter
    import wb_cpu_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int TIMER_BITS = DEFAULT_TIMER_BITS
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        icmu_cyc_i,
    input  logic        icmu_stb_i,
    input  logic        icmu_we_i,
    input  logic [29:0] icmu_addr_i,
    input  logic [2:0]  icmu_cti_i,
    input  logic [1:0]  icmu_bte_i,
    input  logic [3:0]  icmu_sel_i,
    input  logic [31:0] icmu_data_i,
    output logic [31:0] icmu_data_o,
    output logic        icmu_ack_o,

    input  logic        dcmu_cyc_i,
    input  logic        dcmu_stb_i,
    input  logic        dcmu_we_i,
    input  logic [29:0] dcmu_addr_i,
    input  logic [2:0]  dcmu_cti_i,
    input  logic [1:0]  dcmu_bte_i,
    input  logic [3:0]  dcmu_sel_i,
    input  logic [31:0] dcmu_data_i,
    output logic [31:0] dcmu_data_o,
    output logic        dcmu_ack_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [29:0] wbm_addr_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_data_o,
    input  logic [31:0] wbm_data_i,
    input  logic        wbm_ack_i,

    output logic [1:0]  owner,
    output logic        timeout
);

    // Handshake: a master owns the bus for as long as its cyc stays high; each
    // beat is a cycle with stb high and completes in the cycle ack is high.

    arb_state_t state_q, state_d;
    logic       last_d_q;
    logic       blk_i_q, blk_d_q;
    logic       req_i, req_d;
    logic       own_cyc, own_stb;
    logic       timer_inc, timer_clr, expired, timeout_hit;

    assign req_i = icmu_cyc_i && !blk_i_q;
    assign req_d = dcmu_cyc_i && !blk_d_q;

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state_q)
            GNT_I: begin
                own_cyc = icmu_cyc_i;
                own_stb = icmu_stb_i;
            end
            GNT_D: begin
                own_cyc = dcmu_cyc_i;
                own_stb = dcmu_stb_i;
            end
            default: ;
        endcase
    end

    assign timer_inc   = own_cyc && own_stb && !wbm_ack_i;
    assign timer_clr   = (state_q == IDLE) || (state_d != state_q) || wbm_ack_i;
    assign timeout_hit = expired && !rst;

    wb_arb_timer #(
        .TIMEOUT    (TIMEOUT),
        .TIMER_BITS (TIMER_BITS)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i && req_d) begin
                    state_d = last_d_q ? GNT_I : GNT_D;
                end else if (req_i) begin
                    state_d = GNT_I;
                end else if (req_d) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                end else if (!icmu_cyc_i) begin
                    state_d = req_d ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                end else if (!dcmu_cyc_i) begin
                    state_d = req_i ? GNT_I : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A timed-out master stays locked out until it has dropped cyc once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            blk_i_q  <= 1'b0;
            blk_d_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q && state_d == GNT_I) begin
                last_d_q <= 1'b0;
            end else if (state_d != state_q && state_d == GNT_D) begin
                last_d_q <= 1'b1;
            end
            if (timeout_hit && state_q == GNT_I) begin
                blk_i_q <= 1'b1;
            end else if (!icmu_cyc_i) begin
                blk_i_q <= 1'b0;
            end
            if (timeout_hit && state_q == GNT_D) begin
                blk_d_q <= 1'b1;
            end else if (!dcmu_cyc_i) begin
                blk_d_q <= 1'b0;
            end
        end
    end

    always_comb begin
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_addr_o = '0;
        wbm_cti_o  = '0;
        wbm_bte_o  = '0;
        wbm_sel_o  = '0;
        wbm_data_o = '0;
        case (state_q)
            GNT_I: begin
                wbm_cyc_o  = icmu_cyc_i && !timeout_hit;
                wbm_stb_o  = icmu_stb_i && !timeout_hit;
                wbm_we_o   = icmu_we_i;
                wbm_addr_o = icmu_addr_i;
                wbm_cti_o  = icmu_cti_i;
                wbm_bte_o  = icmu_bte_i;
                wbm_sel_o  = icmu_sel_i;
                wbm_data_o = icmu_data_i;
            end
            GNT_D: begin
                wbm_cyc_o  = dcmu_cyc_i && !timeout_hit;
                wbm_stb_o  = dcmu_stb_i && !timeout_hit;
                wbm_we_o   = dcmu_we_i;
                wbm_addr_o = dcmu_addr_i;
                wbm_cti_o  = dcmu_cti_i;
                wbm_bte_o  = dcmu_bte_i;
                wbm_sel_o  = dcmu_sel_i;
                wbm_data_o = dcmu_data_i;
            end
            default: ;
        endcase
    end

    // A forced termination hands the owner an ack carrying zero data
    assign icmu_ack_o  = (state_q == GNT_I) && (wbm_ack_i || timeout_hit);
    assign dcmu_ack_o  = (state_q == GNT_D) && (wbm_ack_i || timeout_hit);
    assign icmu_data_o = (state_q == GNT_I && timeout_hit) ? 32'h0 : wbm_data_i;
    assign dcmu_data_o = (state_q == GNT_D && timeout_hit) ? 32'h0 : wbm_data_i;
    assign owner       = owner_code(state_q);
    assign timeout     = timeout_hit;

endmodule
